buffer_16x4_loader: RTL and testbench

//  Upstream fill controller for the 16x4 word buffer (Buffer_16x4). Streams 32-bit words from a

---
 rtl/buffer_16x4_pkg.sv | 36 +++
 rtl/buffer_16x4_rdpipe.sv | 37 +++
 rtl/buffer_16x4_loader.sv | 187 ++++++++++++++++++
 tb/tb_buffer_16x4_loader.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/buffer_16x4_pkg.sv
// Shared constants and types for the 16x4 word buffer and its fill controller.
package buffer_16x4_pkg;

  localparam int BUF_ROWS = 16;
  localparam int BUF_COLS = 4;
  localparam int BUF_AW   = 6;
  localparam int DATA_W   = 32;
  localparam int MEM_AW   = 16;

  // Buffer address of row 15, column 0: where refill words land.
  localparam logic [5:0] REFILL_BASE     = 6'd60;
  // Last issue index of a full fill (64 words) and of a row refill (4 words).
  localparam logic [5:0] FILL_LAST_IDX   = 6'd63;
  localparam logic [5:0] REFILL_LAST_IDX = 6'd3;

  // Loader FSM state encoding.
  localparam logic [2:0] ST_IDLE_ENC   = 3'd0;
  localparam logic [2:0] ST_FILL_ENC   = 3'd1;
  localparam logic [2:0] ST_READY_ENC  = 3'd2;
  localparam logic [2:0] ST_SHIFT_ENC  = 3'd3;
  localparam logic [2:0] ST_REFILL_ENC = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE   = ST_IDLE_ENC,
    ST_FILL   = ST_FILL_ENC,
    ST_READY  = ST_READY_ENC,
    ST_SHIFT  = ST_SHIFT_ENC,
    ST_REFILL = ST_REFILL_ENC
  } loader_state_t;

  // Map a refill column (0..3) onto its bottom-row buffer address (60..63).
  function automatic logic [5:0] refill_addr(input logic [1:0] col);
    return REFILL_BASE + {4'd0, col};
  endfunction

endpackage

// File: rtl/buffer_16x4_rdpipe.sv
// One-stage read-to-write pipe: carries the write strobe and buffer address
// of each memory read forward one cycle so they line up with mem_rdata.
module buffer_16x4_rdpipe #(
  parameter int DATA_W = 32,
  parameter int BUF_AW = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_valid,
  input  logic [BUF_AW-1:0] rd_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              buf_we,
  output logic [BUF_AW-1:0] buf_address,
  output logic [DATA_W-1:0] buf_data_in
);

  logic              we_r;
  logic [BUF_AW-1:0] addr_r;

  // Delay the read strobe and its target address by one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_r   <= 1'b0;
      addr_r <= '0;
    end else begin
      we_r   <= rd_valid;
      addr_r <= rd_valid ? rd_addr : '0;
    end
  end

  assign buf_we      = we_r;
  assign buf_address = addr_r;
  // Data passes straight from memory; forced to zero when no write is pending
  // so the port reads 0 under reset and between writes.
  assign buf_data_in = we_r ? mem_rdata : '0;

endmodule

// File: rtl/buffer_16x4_loader.sv
// Fill controller for the 16x4 word buffer: full 64-word fill on start,
// then one-row advances (shift up + 4-word refill of row 15) on request.
module buffer_16x4_loader #(
  parameter int DATA_W = buffer_16x4_pkg::DATA_W,
  parameter int BUF_AW = buffer_16x4_pkg::BUF_AW,
  parameter int MEM_AW = buffer_16x4_pkg::MEM_AW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [MEM_AW-1:0] base_addr,
  input  logic              adv_req,
  output logic              adv_ack,
  output logic              buf_ready,
  output logic              busy,
  output logic              mem_rd,
  output logic [MEM_AW-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              buf_we,
  output logic [BUF_AW-1:0] buf_address,
  output logic [DATA_W-1:0] buf_data_in,
  output logic              buf_shift_up
);

  import buffer_16x4_pkg::*;

  localparam logic [MEM_AW-1:0] ADDR_ONE = MEM_AW'(1);

  loader_state_t     state_r, state_s;
  logic [MEM_AW-1:0] ptr_r, ptr_s;      // next memory address to read
  logic [5:0]        idx_r, idx_s;      // index of the read issued this cycle
  logic              rd_r, rd_s;
  logic [MEM_AW-1:0] addr_r, addr_s;
  logic              shift_r, shift_s;
  logic              ack_r, ack_s;
  logic              ready_r, ready_s;
  logic              busy_r, busy_s;
  logic [BUF_AW-1:0] waddr_s;           // buffer slot for the read issued this cycle

  // Next-state and next-output logic; every output is registered one cycle later.
  always_comb begin
    state_s = state_r;
    ptr_s   = ptr_r;
    idx_s   = idx_r;
    rd_s    = 1'b0;
    addr_s  = '0;
    shift_s = 1'b0;
    ack_s   = 1'b0;
    ready_s = 1'b0;
    busy_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_s = ST_FILL;
          rd_s    = 1'b1;
          addr_s  = base_addr;
          ptr_s   = base_addr + ADDR_ONE;
          idx_s   = 6'd0;
          busy_s  = 1'b1;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_FILL: begin
        busy_s = 1'b1;
        if (rd_r && (idx_r != FILL_LAST_IDX)) begin
          rd_s   = 1'b1;
          addr_s = ptr_r;
          ptr_s  = ptr_r + ADDR_ONE;
          idx_s  = idx_r + 6'd1;
        end else if (rd_r) begin
          // Last read issued; its write lands in the next cycle.
          state_s = ST_FILL;
        end else begin
          state_s = ST_READY;
          busy_s  = 1'b0;
          ready_s = 1'b1;
        end
      end
      ST_READY: begin
        ready_s = 1'b1;
        if (start) begin
          // Restart wins over an advance; adv_req stays pending until after the fill.
          state_s = ST_FILL;
          rd_s    = 1'b1;
          addr_s  = base_addr;
          ptr_s   = base_addr + ADDR_ONE;
          idx_s   = 6'd0;
          busy_s  = 1'b1;
          ready_s = 1'b0;
        end else if (adv_req && !ack_r) begin
          // A request still held during its own ack cycle is the one being acked.
          state_s = ST_SHIFT;
          shift_s = 1'b1;
          busy_s  = 1'b1;
          ready_s = 1'b0;
        end else begin
          state_s = ST_READY;
        end
      end
      ST_SHIFT: begin
        state_s = ST_REFILL;
        busy_s  = 1'b1;
        rd_s    = 1'b1;
        addr_s  = ptr_r;
        ptr_s   = ptr_r + ADDR_ONE;
        idx_s   = 6'd0;
      end
      ST_REFILL: begin
        busy_s = 1'b1;
        if (rd_r && (idx_r != REFILL_LAST_IDX)) begin
          rd_s   = 1'b1;
          addr_s = ptr_r;
          ptr_s  = ptr_r + ADDR_ONE;
          idx_s  = idx_r + 6'd1;
        end else if (rd_r) begin
          state_s = ST_REFILL;
        end else begin
          state_s = ST_READY;
          busy_s  = 1'b0;
          ready_s = 1'b1;
          ack_s   = 1'b1;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Buffer slot for the read in flight: linear index in a fill, bottom row in a refill.
  always_comb begin
    waddr_s = '0;
    if (state_r == ST_REFILL) begin
      waddr_s = BUF_AW'(refill_addr(idx_r[1:0]));
    end else begin
      waddr_s = BUF_AW'(idx_r);
    end
  end

  // State, pointer and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      ptr_r   <= '0;
      idx_r   <= 6'd0;
      rd_r    <= 1'b0;
      addr_r  <= '0;
      shift_r <= 1'b0;
      ack_r   <= 1'b0;
      ready_r <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      ptr_r   <= ptr_s;
      idx_r   <= idx_s;
      rd_r    <= rd_s;
      addr_r  <= addr_s;
      shift_r <= shift_s;
      ack_r   <= ack_s;
      ready_r <= ready_s;
      busy_r  <= busy_s;
    end
  end

  buffer_16x4_rdpipe #(
    .DATA_W (DATA_W),
    .BUF_AW (BUF_AW)
  ) u_rdpipe (
    .clk         (clk),
    .rst         (rst),
    .rd_valid    (rd_r),
    .rd_addr     (waddr_s),
    .mem_rdata   (mem_rdata),
    .buf_we      (buf_we),
    .buf_address (buf_address),
    .buf_data_in (buf_data_in)
  );

  assign mem_rd       = rd_r;
  assign mem_addr     = addr_r;
  assign buf_shift_up = shift_r;
  assign adv_ack      = ack_r;
  assign buf_ready    = ready_r;
  assign busy         = busy_r;

endmodule

// File: tb/tb_buffer_16x4_loader.sv
// Self-checking bench for buffer_16x4_loader: schedule-based reference model,
// per-cycle compare, mirrored buffer contents and hand-computed literal checks.
module tb_buffer_16x4_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] base_addr;
  logic        adv_req;
  logic        adv_ack;
  logic        buf_ready;
  logic        busy;
  logic        mem_rd;
  logic [15:0] mem_addr;
  logic [31:0] mem_rdata = 32'h0;
  logic        buf_we;
  logic [5:0]  buf_address;
  logic [31:0] buf_data_in;
  logic        buf_shift_up;

  always #5 clk = ~clk;

  buffer_16x4_loader dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .base_addr    (base_addr),
    .adv_req      (adv_req),
    .adv_ack      (adv_ack),
    .buf_ready    (buf_ready),
    .busy         (busy),
    .mem_rd       (mem_rd),
    .mem_addr     (mem_addr),
    .mem_rdata    (mem_rdata),
    .buf_we       (buf_we),
    .buf_address  (buf_address),
    .buf_data_in  (buf_data_in),
    .buf_shift_up (buf_shift_up)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Sync-read memory: mem[a] = A000_0000 | a, one cycle after the strobe.
  always @(posedge clk) begin
    if (mem_rd) mem_rdata <= 32'hA000_0000 | {16'h0000, mem_addr};
  end

  // Mirror of the buffer contents, driven by the loader's write/shift strobes.
  logic [31:0] mirror [64];
  always @(posedge clk) begin
    if (buf_shift_up) begin
      for (int i = 0; i < 60; i++) mirror[i] <= mirror[i+4];
    end else if (buf_we) begin
      mirror[buf_address] <= buf_data_in;
    end
  end

  // Reference model: an operation is a timeline counted in cycles since it began.
  // mode 0 idle, 1 full fill, 2 ready, 3 advance.
  int          m_mode  = 0;
  int          m_t     = 0;
  logic [15:0] m_fbase = 16'h0;
  logic [15:0] m_abase = 16'h0;
  logic [15:0] m_next  = 16'h0;
  logic        m_ack   = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_mode <= 0;
      m_t    <= 0;
      m_ack  <= 1'b0;
      m_next <= 16'h0;
    end else begin
      m_ack <= 1'b0;
      case (m_mode)
        0, 2: begin
          if (start) begin
            m_mode  <= 1;
            m_t     <= 1;
            m_fbase <= base_addr;
            m_next  <= base_addr + 16'd64;
          end else if (m_mode == 2 && adv_req && !m_ack) begin
            m_mode  <= 3;
            m_t     <= 1;
            m_abase <= m_next;
            m_next  <= m_next + 16'd4;
          end
        end
        1: if (m_t == 65) m_mode <= 2; else m_t <= m_t + 1;
        3: if (m_t == 6) begin m_mode <= 2; m_ack <= 1'b1; end else m_t <= m_t + 1;
        default: m_mode <= 0;
      endcase
    end
  end

  // Per-cycle compare of every output against the model's timeline.
  always @(negedge clk) begin
    logic        e_rd, e_we, e_sh, e_ack, e_rdy, e_busy;
    logic [15:0] e_addr, a;
    logic [5:0]  e_wa;
    logic [31:0] e_wd;
    e_rd = 1'b0; e_we = 1'b0; e_sh = 1'b0; e_ack = 1'b0; e_rdy = 1'b0; e_busy = 1'b0;
    e_addr = 16'h0; e_wa = 6'd0; e_wd = 32'h0; a = 16'h0;
    case (m_mode)
      1: begin
        e_busy = 1'b1;
        if (m_t <= 64) begin e_rd = 1'b1; e_addr = m_fbase + 16'(m_t - 1); end
        if (m_t >= 2) begin
          e_we = 1'b1; e_wa = 6'(m_t - 2);
          a = m_fbase + 16'(m_t - 2); e_wd = 32'hA000_0000 | {16'h0000, a};
        end
      end
      2: begin e_rdy = 1'b1; e_ack = m_ack; end
      3: begin
        e_busy = 1'b1;
        e_sh = (m_t == 1);
        if (m_t >= 2 && m_t <= 5) begin e_rd = 1'b1; e_addr = m_abase + 16'(m_t - 2); end
        if (m_t >= 3) begin
          e_we = 1'b1; e_wa = 6'(60 + m_t - 3);
          a = m_abase + 16'(m_t - 3); e_wd = 32'hA000_0000 | {16'h0000, a};
        end
      end
      default: ;
    endcase
    chk("mem_rd",       32'(mem_rd),       32'(e_rd));
    chk("buf_we",       32'(buf_we),       32'(e_we));
    chk("buf_shift_up", 32'(buf_shift_up), 32'(e_sh));
    chk("adv_ack",      32'(adv_ack),      32'(e_ack));
    chk("buf_ready",    32'(buf_ready),    32'(e_rdy));
    chk("busy",         32'(busy),         32'(e_busy));
    if (e_rd) chk("mem_addr", 32'(mem_addr), 32'(e_addr));
    if (e_we) begin
      chk("buf_address", 32'(buf_address), 32'(e_wa));
      chk("buf_data_in", buf_data_in, e_wd);
    end
  end

  // Pulse start with base b and count cycles until buf_ready (bounded).
  task automatic do_fill(input logic [15:0] b, output int n);
    @(negedge clk); start = 1'b1; base_addr = b; n = 0;
    do begin @(negedge clk); n++; start = 1'b0; end while (!buf_ready && n < 200);
  endtask

  // Raise adv_req and count cycles until adv_ack (bounded), then drop it.
  task automatic do_adv(output int n);
    @(negedge clk); adv_req = 1'b1; n = 0;
    do begin @(negedge clk); n++; end while (!adv_ack && n < 50);
    adv_req = 1'b0;
  endtask

  // Everything must be zero while reset is asserted.
  task automatic chk_all_zero(input string tag);
    chk({tag, "_ack"},   32'(adv_ack),      32'd0);
    chk({tag, "_ready"}, 32'(buf_ready),    32'd0);
    chk({tag, "_busy"},  32'(busy),         32'd0);
    chk({tag, "_rd"},    32'(mem_rd),       32'd0);
    chk({tag, "_maddr"}, 32'(mem_addr),     32'd0);
    chk({tag, "_we"},    32'(buf_we),       32'd0);
    chk({tag, "_baddr"}, 32'(buf_address),  32'd0);
    chk({tag, "_data"},  buf_data_in,       32'd0);
    chk({tag, "_shift"}, 32'(buf_shift_up), 32'd0);
  endtask

  initial begin
    int n;
    int hits;
    rst = 1'b1; start = 1'b0; adv_req = 1'b0; base_addr = 16'h0;
    repeat (3) @(negedge clk);
    chk_all_zero("t1_por");
    rst = 1'b0;
    @(negedge clk);
    chk("t1_idle_busy", 32'(busy), 32'd0);

    // T1: asynchronous reset in the middle of a fill.
    @(negedge clk); start = 1'b1; base_addr = 16'h0100;
    @(negedge clk); start = 1'b0;
    repeat (10) @(negedge clk);
    chk("t1_midfill_busy", 32'(busy), 32'd1);
    #2 rst = 1'b1;
    #1 chk_all_zero("t1_async");
    @(negedge clk); rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("t1_after_busy",  32'(busy),      32'd0);
    chk("t1_after_ready", 32'(buf_ready), 32'd0);

    // T2: full fill from 0x0010.
    do_fill(16'h0010, n);
    chk("t2_latency", 32'(n), 32'd66);
    chk("t2_m0",  mirror[0],  32'hA000_0010);
    chk("t2_m31", mirror[31], 32'hA000_002F);
    chk("t2_m63", mirror[63], 32'hA000_004F);

    // T3: one advance.
    do_adv(n);
    chk("t3_latency", 32'(n), 32'd7);
    chk("t3_m0",  mirror[0],  32'hA000_0014);
    chk("t3_m3",  mirror[3],  32'hA000_0017);
    chk("t3_m56", mirror[56], 32'hA000_004C);
    chk("t3_m60", mirror[60], 32'hA000_0050);
    chk("t3_m63", mirror[63], 32'hA000_0053);

    // T4: address wrap.
    do_fill(16'hFFFE, n);
    chk("t4_latency", 32'(n), 32'd66);
    chk("t4_m0",  mirror[0],  32'hA000_FFFE);
    chk("t4_m1",  mirror[1],  32'hA000_FFFF);
    chk("t4_m2",  mirror[2],  32'hA000_0000);
    chk("t4_m63", mirror[63], 32'hA000_003D);
    do_adv(n);
    chk("t4_adv_latency", 32'(n), 32'd7);
    chk("t4_adv_m63", mirror[63], 32'hA000_0041);

    // T5a: start during a fill is ignored.
    @(negedge clk); start = 1'b1; base_addr = 16'h0200; n = 0;
    @(negedge clk); start = 1'b0; n++;
    repeat (5) begin @(negedge clk); n++; end
    start = 1'b1; base_addr = 16'h4000;
    @(negedge clk); start = 1'b0; n++;
    while (!buf_ready && n < 200) begin @(negedge clk); n++; end
    chk("t5_latency", 32'(n), 32'd66);
    chk("t5_m0",  mirror[0],  32'hA000_0200);
    chk("t5_m63", mirror[63], 32'hA000_023F);

    // T5b: start and adv_req together in READY: fill first, then advance.
    @(negedge clk); start = 1'b1; base_addr = 16'h0500; adv_req = 1'b1; n = 0;
    @(negedge clk); start = 1'b0; n++;
    while (!adv_ack && n < 200) begin @(negedge clk); n++; end
    adv_req = 1'b0;
    chk("t5_coll_latency", 32'(n), 32'd73);
    chk("t5_coll_m0",  mirror[0],  32'hA000_0504);
    chk("t5_coll_m63", mirror[63], 32'hA000_0543);

    // T6: reset after the second refill write.
    @(negedge clk); adv_req = 1'b1;
    repeat (4) @(negedge clk);
    chk("t6_we2",    32'(buf_we),      32'd1);
    chk("t6_waddr2", 32'(buf_address), 32'd61);
    #2 rst = 1'b1; adv_req = 1'b0;
    #1 chk_all_zero("t6_async");
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    chk("t6_after_busy",  32'(busy),      32'd0);
    chk("t6_after_ready", 32'(buf_ready), 32'd0);

    // T5c: adv_req in IDLE produces neither shift nor ack.
    adv_req = 1'b1; hits = 0;
    repeat (10) begin
      @(negedge clk);
      if (adv_ack || buf_shift_up || busy) hits++;
    end
    adv_req = 1'b0;
    chk("t5_idle_adv", 32'(hits), 32'd0);

    // T6: a fresh start refills cleanly.
    do_fill(16'h0300, n);
    chk("t6_latency", 32'(n), 32'd66);
    chk("t6_m0",  mirror[0],  32'hA000_0300);
    chk("t6_m63", mirror[63], 32'hA000_033F);
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
